// File: rtl/fp16_pkg.sv
// Shared fp16 constants, FSM state encoding and field helpers for the MAC engine.
package fp16_pkg;

    localparam logic signed [7:0] EXP_BIAS = 8'sd15;
    localparam logic signed [7:0] EXP_MAX  = 8'sd31;
    localparam logic [15:0]       QNAN     = 16'h7E00;
    localparam logic [15:0]       POS_INF  = 16'h7C00;
    localparam logic [15:0]       MAX_FIN  = 16'h7BFF;

    typedef enum logic [2:0] {
        IDLE,
        MUL,
        ALIGN,
        ADD,
        PACK
    } state_t;

    typedef struct packed {
        logic       sign;
        logic [4:0] exp;
        logic [9:0] man;
    } fp16_t;

    function automatic fp16_t fp_unpack(input logic [15:0] x);
        return fp16_t'(x);
    endfunction

    // Exponent 0 covers subnormals too: they are flushed to signed zero.
    function automatic logic fp_is_zero(input logic [4:0] e);
        return ~|e;
    endfunction

    function automatic logic fp_is_inf(input logic [4:0] e, input logic [9:0] m);
        return (&e) & ~|m;
    endfunction

    function automatic logic fp_is_nan(input logic [4:0] e, input logic [9:0] m);
        return (&e) & (|m);
    endfunction

endpackage

// File: rtl/fp16_round_pack.sv
// Normalise (LZC), round-to-nearest-even and range-check a wide mantissa into fp16.
// Value of mant_i is mant_i / 2^(W-2) * 2^(exp_i-15); pure combinational, no handshake.
module fp16_round_pack
    import fp16_pkg::*;
#(
    parameter int W          = 15,
    parameter bit SAT_ON_OVF = 1'b0
) (
    input  logic              sign_i,
    input  logic signed [7:0] exp_i,
    input  logic [W-1:0]      mant_i,
    output logic [15:0]       res_o,
    output logic              ovf_o,
    output logic              unf_o
);

    logic [4:0]        lead;
    logic [4:0]        lz;
    logic [W-1:0]      mant_n;
    logic signed [7:0] e_n;
    logic signed [7:0] e_r;
    logic [10:0]       m11;
    logic              g_bit;
    logic              s_bit;
    logic              rnd;
    logic [11:0]       m_r;
    logic [9:0]        frac;

    always_comb begin
        lead = 5'd0;
        for (int i = 0; i < W; i++) begin
            if (mant_i[i]) lead = 5'(i);
        end
        lz     = 5'(W - 1) - lead;
        mant_n = mant_i << lz;
        e_n    = exp_i + 8'sd1 - $signed({3'b000, lz});

        m11   = mant_n[W-1 -: 11];
        g_bit = mant_n[W-12];
        s_bit = |mant_n[W-13:0];
        rnd   = g_bit & (s_bit | m11[0]);
        m_r   = {1'b0, m11} + {11'd0, rnd};

        // Rounding carry out of the hidden bit leaves mantissa 1.000 one binade up.
        e_r  = m_r[11] ? (e_n + 8'sd1) : e_n;
        frac = m_r[11] ? 10'd0 : m_r[9:0];

        res_o = {sign_i, e_r[4:0], frac};
        ovf_o = 1'b0;
        unf_o = 1'b0;
        if (~|m_r) begin
            res_o = 16'h0000;
        end else if (e_r >= EXP_MAX) begin
            ovf_o = 1'b1;
            res_o = SAT_ON_OVF ? {sign_i, MAX_FIN[14:0]} : {sign_i, POS_INF[14:0]};
        end else if (e_r <= 8'sd0) begin
            unf_o = 1'b1;
            res_o = {sign_i, 15'd0};
        end
    end

endmodule

// File: rtl/fp16_mac_seq.sv
// Sequential fp16 multiply-accumulate (non-fused, RNE twice): acc <= acc + a*b.
// Latency 4 edges accept->acc, acc_valid pulse next cycle; in_ready low while busy (1 pair / 5 cycles).
module fp16_mac_seq
    import fp16_pkg::*;
#(
    parameter bit          SAT_ON_OVF = 1'b0,
    parameter logic [15:0] ACC_INIT   = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] acc,
    output logic        acc_valid,
    output logic        busy,
    output logic [2:0]  flags
);

    state_t state_q, state_d;

    logic [15:0]       a_q, b_q;
    logic [15:0]       prod_q;
    logic [2:0]        pflg_q;
    logic              spec_q;
    logic [15:0]       spec_res_q;
    logic              sinv_q;
    logic [13:0]       big_q, small_q;
    logic signed [7:0] exp_q;
    logic              sign_q;
    logic              sub_q;
    logic [14:0]       sum_q;
    logic [15:0]       acc_q;
    logic [2:0]        flags_q;
    logic              acc_vld_q;

    // ---------------- FSM ----------------
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = (state_q == IDLE && in_valid) ? MUL : IDLE;
        end else begin
            unique case (state_q)
                IDLE:    if (in_valid) state_d = MUL;
                MUL:     state_d = ALIGN;
                ALIGN:   state_d = ADD;
                ADD:     state_d = PACK;
                PACK:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // ---------------- MUL stage ----------------
    fp16_t             ua, ub;
    logic              mul_sign;
    logic signed [7:0] exp_p;
    logic [21:0]       prod22;
    logic [15:0]       mul_rp;
    logic              mul_ovf, mul_unf;
    logic [15:0]       mul_res;
    logic [2:0]        mul_flg;
    logic              a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

    always_comb begin
        ua       = fp_unpack(a_q);
        ub       = fp_unpack(b_q);
        mul_sign = ua.sign ^ ub.sign;
        exp_p    = $signed({3'b000, ua.exp}) + $signed({3'b000, ub.exp}) - EXP_BIAS;
        prod22   = 22'({1'b1, ua.man}) * 22'({1'b1, ub.man});
        a_zero   = fp_is_zero(ua.exp);
        b_zero   = fp_is_zero(ub.exp);
        a_inf    = fp_is_inf(ua.exp, ua.man);
        b_inf    = fp_is_inf(ub.exp, ub.man);
        a_nan    = fp_is_nan(ua.exp, ua.man);
        b_nan    = fp_is_nan(ub.exp, ub.man);
    end

    fp16_round_pack #(.W(22), .SAT_ON_OVF(SAT_ON_OVF)) u_mul_rp (
        .sign_i (mul_sign),
        .exp_i  (exp_p),
        .mant_i (prod22),
        .res_o  (mul_rp),
        .ovf_o  (mul_ovf),
        .unf_o  (mul_unf)
    );

    always_comb begin
        mul_res = mul_rp;
        mul_flg = {1'b0, mul_ovf, mul_unf};
        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
            mul_res = QNAN;
            mul_flg = 3'b100;
        end else if (a_inf || b_inf) begin
            mul_res = {mul_sign, POS_INF[14:0]};
            mul_flg = 3'b000;
        end else if (a_zero || b_zero) begin
            mul_res = {mul_sign, 15'd0};
            mul_flg = 3'b000;
        end
    end

    // ---------------- ALIGN stage ----------------
    fp16_t       up, uc;
    logic        p_ge;
    logic [4:0]  e_big, e_sml, d_sh;
    logic [9:0]  m_big, m_sml;
    logic [13:0] sml14, al_big, al_sml;
    logic        lost;
    logic        al_spec, al_inv;
    logic [15:0] al_res;
    logic        p_zero, c_zero, p_inf, c_inf, p_nan, c_nan;

    always_comb begin
        up     = fp_unpack(prod_q);
        uc     = fp_unpack(acc_q);
        p_zero = fp_is_zero(up.exp);
        c_zero = fp_is_zero(uc.exp);
        p_inf  = fp_is_inf(up.exp, up.man);
        c_inf  = fp_is_inf(uc.exp, uc.man);
        p_nan  = fp_is_nan(up.exp, up.man);
        c_nan  = fp_is_nan(uc.exp, uc.man);

        // Ordering by magnitude keeps the subtraction result non-negative.
        p_ge   = {up.exp, up.man} >= {uc.exp, uc.man};
        e_big  = p_ge ? up.exp : uc.exp;
        e_sml  = p_ge ? uc.exp : up.exp;
        m_big  = p_ge ? up.man : uc.man;
        m_sml  = p_ge ? uc.man : up.man;
        d_sh   = e_big - e_sml;
        al_big = {1'b1, m_big, 3'b000};
        sml14  = {1'b1, m_sml, 3'b000};
        lost   = |(sml14 & ((14'd1 << d_sh) - 14'd1));
        al_sml = (sml14 >> d_sh) | {13'd0, lost};

        al_spec = 1'b1;
        al_inv  = 1'b0;
        al_res  = QNAN;
        if (p_nan || c_nan) begin
            al_res = QNAN;
        end else if (p_inf && c_inf && (up.sign != uc.sign)) begin
            al_res = QNAN;
            al_inv = 1'b1;
        end else if (p_inf) begin
            al_res = prod_q;
        end else if (c_inf) begin
            al_res = acc_q;
        end else if (p_zero && c_zero) begin
            al_res = {up.sign & uc.sign, 15'd0};
        end else if (p_zero) begin
            al_res = acc_q;
        end else if (c_zero) begin
            al_res = prod_q;
        end else begin
            al_spec = 1'b0;
        end
    end

    // ---------------- ADD / PACK stages ----------------
    logic [14:0] sum_d;
    logic [15:0] add_rp;
    logic        add_ovf, add_unf;
    logic [15:0] pack_res;
    logic [2:0]  pack_flg;

    always_comb begin
        sum_d = sub_q ? ({1'b0, big_q} - {1'b0, small_q})
                      : ({1'b0, big_q} + {1'b0, small_q});
    end

    fp16_round_pack #(.W(15), .SAT_ON_OVF(SAT_ON_OVF)) u_add_rp (
        .sign_i (sign_q),
        .exp_i  (exp_q),
        .mant_i (sum_q),
        .res_o  (add_rp),
        .ovf_o  (add_ovf),
        .unf_o  (add_unf)
    );

    always_comb begin
        pack_res = spec_q ? spec_res_q : add_rp;
        pack_flg = pflg_q | (spec_q ? {sinv_q, 2'b00} : {1'b0, add_ovf, add_unf});
    end

    // ---------------- registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            acc_q     <= ACC_INIT;
            flags_q   <= 3'b000;
            acc_vld_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_vld_q <= 1'b0;
            if (clear) begin
                acc_q   <= ACC_INIT;
                flags_q <= 3'b000;
            end else if (state_q == PACK) begin
                acc_q     <= pack_res;
                flags_q   <= flags_q | pack_flg;
                acc_vld_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == IDLE && in_valid) begin
            a_q <= a;
            b_q <= b;
        end
        if (state_q == MUL) begin
            prod_q <= mul_res;
            pflg_q <= mul_flg;
        end
        if (state_q == ALIGN) begin
            spec_q     <= al_spec;
            spec_res_q <= al_res;
            sinv_q     <= al_inv;
            big_q      <= al_big;
            small_q    <= al_sml;
            exp_q      <= $signed({3'b000, e_big});
            sign_q     <= p_ge ? up.sign : uc.sign;
            sub_q      <= up.sign ^ uc.sign;
        end
        if (state_q == ADD) begin
            sum_q <= sum_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = ~in_ready;
    assign acc       = acc_q;
    assign acc_valid = acc_vld_q;
    assign flags     = flags_q;

endmodule

// File: tb/tb_fp16_mac_seq.sv
// Scoreboard bench: directed operand pairs drive a default and a saturating engine in lockstep.
module tb_fp16_mac_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clear = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] a = 16'h0000;
    logic [15:0] b = 16'h0000;

    logic        in_ready0, in_ready1, acc_valid0, acc_valid1, busy0, busy1;
    logic [15:0] acc0, acc1;
    logic [2:0]  flags0, flags1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [15:0] e0;
        logic [15:0] e1;
        logic [2:0]  f;
    } exp_t;
    exp_t q[$];

    always #5 clk = ~clk;

    fp16_mac_seq #(.SAT_ON_OVF(1'b0), .ACC_INIT(16'h0000)) u_dut0 (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready0),
        .a(a), .b(b), .acc(acc0), .acc_valid(acc_valid0), .busy(busy0), .flags(flags0)
    );

    fp16_mac_seq #(.SAT_ON_OVF(1'b1), .ACC_INIT(16'h0000)) u_dut1 (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready1),
        .a(a), .b(b), .acc(acc1), .acc_valid(acc_valid1), .busy(busy1), .flags(flags1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: every acc_valid pulse consumes one scoreboard entry.
    always @(negedge clk) begin
        if (acc_valid0 || acc_valid1) begin
            chk("valid_lockstep", {31'd0, acc_valid1}, {31'd0, acc_valid0});
            if (q.size() == 0) begin
                chk("unexpected_acc_valid", 32'd1, 32'd0);
            end else begin
                exp_t x;
                x = q.pop_front();
                chk("acc_inf_mode", {16'd0, acc0}, {16'd0, x.e0});
                chk("acc_sat_mode", {16'd0, acc1}, {16'd0, x.e1});
                chk("flags_inf_mode", {29'd0, flags0}, {29'd0, x.f});
                chk("flags_sat_mode", {29'd0, flags1}, {29'd0, x.f});
            end
        end
    end

    task automatic send(input logic [15:0] ta, input logic [15:0] tb, input logic clr,
                        input logic push, input logic [15:0] e0, input logic [15:0] e1,
                        input logic [2:0] ef);
        int n;
        exp_t x;
        n = 0;
        @(negedge clk);
        while (!in_ready0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready0) chk("in_ready_timeout", 32'd0, 32'd1);
        a        = ta;
        b        = tb;
        clear    = clr;
        in_valid = 1'b1;
        if (push) begin
            x.e0 = e0; x.e1 = e1; x.f = ef;
            q.push_back(x);
        end
        @(negedge clk);
        in_valid = 1'b0;
        clear    = 1'b0;
        a        = 16'hDEAD;
        b        = 16'hBEEF;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((q.size() != 0 || !in_ready0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0 || !in_ready0) chk("drain_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_clear();
        wait_idle();
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk("clear_acc0", {16'd0, acc0}, 32'h0);
        chk("clear_acc1", {16'd0, acc1}, 32'h0);
        chk("clear_flags", {29'd0, flags0}, 32'h0);
    endtask

    logic [15:0] cnt_exp [8];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        cnt_exp[0] = 16'h3C00; cnt_exp[1] = 16'h4000; cnt_exp[2] = 16'h4200; cnt_exp[3] = 16'h4400;
        cnt_exp[4] = 16'h4500; cnt_exp[5] = 16'h4600; cnt_exp[6] = 16'h4700; cnt_exp[7] = 16'h4800;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset_acc", {16'd0, acc0}, 32'h0);
        chk("reset_flags", {29'd0, flags0}, 32'h0);
        chk("reset_in_ready", {31'd0, in_ready0}, 32'h1);
        chk("reset_busy", {31'd0, busy0}, 32'h0);
        chk("reset_acc_valid", {31'd0, acc_valid0}, 32'h0);

        // 1.0*2.0, with explicit latency check
        send(16'h3C00, 16'h4000, 1'b0, 1'b1, 16'h4000, 16'h4000, 3'b000);
        repeat (3) @(negedge clk);
        chk("latency_acc_old", {16'd0, acc0}, 32'h0);
        chk("latency_busy", {31'd0, busy0}, 32'h1);
        @(negedge clk);
        chk("latency_acc_new", {16'd0, acc0}, 32'h4000);
        chk("latency_valid", {31'd0, acc_valid0}, 32'h1);
        send(16'h4000, 16'h4000, 1'b0, 1'b1, 16'h4600, 16'h4600, 3'b000);

        // Eight 1.0*1.0 pairs, first one with clear in the same cycle
        for (int i = 0; i < 8; i++)
            send(16'h3C00, 16'h3C00, (i == 0), 1'b1, cnt_exp[i], cnt_exp[i], 3'b000);

        send(16'h3E00, 16'h3E00, 1'b1, 1'b1, 16'h4080, 16'h4080, 3'b000);

        // Exact cancellation gives +0
        send(16'h3C00, 16'h4000, 1'b1, 1'b1, 16'h4000, 16'h4000, 3'b000);
        send(16'hBC00, 16'h4000, 1'b0, 1'b1, 16'h0000, 16'h0000, 3'b000);

        // Overflow: Inf vs saturate
        send(16'h7BFF, 16'h4000, 1'b0, 1'b1, 16'h7C00, 16'h7BFF, 3'b010);

        // Inf*0 invalid, NaN persists, then clear
        send(16'h7C00, 16'h0000, 1'b1, 1'b1, 16'h7E00, 16'h7E00, 3'b100);
        send(16'h3C00, 16'h3C00, 1'b0, 1'b1, 16'h7E00, 16'h7E00, 3'b100);
        do_clear();

        // RNE: above-half rounds up, exact tie stays even
        send(16'h3C00, 16'h3C00, 1'b0, 1'b1, 16'h3C00, 16'h3C00, 3'b000);
        send(16'h1200, 16'h3C00, 1'b0, 1'b1, 16'h3C01, 16'h3C01, 3'b000);
        send(16'h3C00, 16'h3C00, 1'b1, 1'b1, 16'h3C00, 16'h3C00, 3'b000);
        send(16'h1000, 16'h3C00, 1'b0, 1'b1, 16'h3C00, 16'h3C00, 3'b000);

        // Unlike-sign, different exponents; subnormal input flushed
        send(16'h3C00, 16'h4000, 1'b1, 1'b1, 16'h4000, 16'h4000, 3'b000);
        send(16'hB800, 16'h3C00, 1'b0, 1'b1, 16'h3E00, 16'h3E00, 3'b000);
        send(16'h0001, 16'h3C00, 1'b0, 1'b1, 16'h3E00, 16'h3E00, 3'b000);

        // Product below 2^-14 flushes and sets underflow
        send(16'h0400, 16'h3800, 1'b1, 1'b1, 16'h0000, 16'h0000, 3'b001);

        // Inf + -Inf
        send(16'h7C00, 16'h3C00, 1'b1, 1'b1, 16'h7C00, 16'h7C00, 3'b000);
        send(16'hFC00, 16'h3C00, 1'b0, 1'b1, 16'h7E00, 16'h7E00, 3'b100);

        // Clear while busy aborts the operation
        send(16'h3C00, 16'h3C00, 1'b0, 1'b0, 16'h0, 16'h0, 3'b000);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk("abort_clear_ready", {31'd0, in_ready0}, 32'h1);
        chk("abort_clear_acc", {16'd0, acc0}, 32'h0);
        chk("abort_clear_flags", {29'd0, flags0}, 32'h0);
        repeat (6) @(negedge clk);

        // Reset during ADD discards the pair
        send(16'h3C00, 16'h4000, 1'b0, 1'b1, 16'h4000, 16'h4000, 3'b000);
        send(16'h4000, 16'h4000, 1'b0, 1'b0, 16'h0, 16'h0, 3'b000);
        repeat (2) @(negedge clk);
        chk("rst_mid_busy", {31'd0, busy0}, 32'h1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_acc", {16'd0, acc0}, 32'h0);
        chk("rst_mid_ready", {31'd0, in_ready0}, 32'h1);
        chk("rst_mid_flags", {29'd0, flags0}, 32'h0);
        repeat (8) @(negedge clk);

        wait_idle();
        chk("scoreboard_empty", q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
